eq_mac_scheduler: RTL and testbench
===================================

Name: eq_mac_scheduler

Overview:
Sequences the shared tap-MAC datapath (tap counter, phase flags, coefficient fetch, accumulator) across all equalizer bands for each incoming audio sample. It accepts one sample strobe per frame and issues NUM_BANDS x TAPS MAC operations, one per clock. It generates accumulator clear/last markers and emits per-band completion pulses aligned to the MAC pipeline latency. It sits between the audio sample interface and the per-band filter datapath.

Parameters:
NUM_BANDS, 8, number of equalizer bands sharing the MAC
TAPS, 64, taps per band filter (power of two)
BAND_W, 3, log2(NUM_BANDS)
TAP_W, 6, log2(TAPS)
MAC_LATENCY, 2, clocks from tap issue to accumulator update (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low
sample_valid  in  1  new input sample available
sample_ready  out  1  scheduler can accept a sample (IDLE only)
stall  in  1  hold tap issue for this cycle
overrun_clr  in  1  clear sticky overrun flag
clk_enable  out  1  MAC issue strobe, one per tap operation
band_idx  out  BAND_W  band of the issued tap
tap_idx  out  TAP_W  tap index of the issued tap
coeff_addr  out  BAND_W+TAP_W  {band_idx, tap_idx}
acc_clear  out  1  issued tap is tap 0 (phase_0)
acc_last  out  1  issued tap is tap TAPS-1 (phase_63)
band_done  out  1  pulse: band result final in accumulator
band_done_idx  out  BAND_W  band index for band_done
frame_done  out  1  pulse: all bands complete for this sample
busy  out  1  state != IDLE
overrun  out  1  sticky: sample_valid seen while busy

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except sample_ready=1; delay line cleared. Reset mid-frame aborts with no band_done/frame_done.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: sample_ready=1, clk_enable=0, band_idx=tap_idx=0. sample_valid=1 -> RUN next cycle with band=0, tap=0.
- RUN: clk_enable=!stall. Each non-stalled cycle issues (band_idx, tap_idx), then tap increments; at tap==TAPS-1 tap wraps to 0 and band increments. acc_clear = clk_enable && tap==0; acc_last = clk_enable && tap==TAPS-1. Stalled cycle: counters hold, clk_enable/acc_clear/acc_last=0. After issuing band NUM_BANDS-1 tap TAPS-1 -> DRAIN.
- DRAIN: exactly MAC_LATENCY cycles, clk_enable=0, then DONE.
- DONE: one cycle, frame_done=1, then IDLE.
- band_done/band_done_idx: acc_last and band_idx delayed by MAC_LATENCY clocks via free-running shift register (advances every clock, independent of stall). Last band_done falls in final DRAIN cycle.
- Latency (no stall, MAC_LATENCY=2): accept at cycle t; first issue t+1; last issue t+512; band k done at t+64*(k+1)+2; frame_done t+515; sample_ready again t+516.
- Overrun: sample_valid while state!=IDLE sets overrun, sample dropped, frame unaffected. overrun_clr clears; simultaneous set and clear -> set wins.
- sample_valid in DONE: not accepted (ready=0), flags overrun.
- coeff_addr purely combinational concat of registered band_idx/tap_idx.

Test Plan:
- Reset then sample_valid pulse at cycle 10 -> clk_enable high cycles 11..522, acc_clear at 11,75,...,459, acc_last at 74,138,...,522, frame_done at 525, sample_ready=1 at 526.
- Same run -> band_done pulses at 76,140,...,524 with band_done_idx 0..7; coeff_addr increments 0..511 contiguously.
- stall=1 for 3 cycles at band 2 tap 10 -> tap/band hold, clk_enable=0 during stall, frame_done delayed to cycle 528, no skipped or duplicated coeff_addr.
- sample_valid at cycle 200 during RUN -> overrun=1, frame timing unchanged; overrun_clr and sample_valid same cycle at 300 -> overrun stays 1; overrun_clr alone at 400 -> overrun=0.
- rst asserted at cycle 300 mid-frame -> outputs immediately reset values, no band_done/frame_done after release; next sample starts fresh from band 0 tap 0.
- Back-to-back: sample_valid held high continuously -> new frame accepted exactly at every sample_ready cycle (period 516), overrun set from busy cycles.

Source files
------------

// File: rtl/eq_mac_scheduler.sv
// Tap-MAC issue sequencer for the shared equalizer datapath: walks every band/tap
// once per accepted sample, marks accumulator clear/last and reports band/frame completion.
module eq_mac_scheduler #(
  parameter int NUM_BANDS   = 8,
  parameter int TAPS        = 64,
  parameter int BAND_W      = 3,
  parameter int TAP_W       = 6,
  parameter int MAC_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic                    stall,
  input  logic                    overrun_clr,
  output logic                    clk_enable,
  output logic [BAND_W-1:0]       band_idx,
  output logic [TAP_W-1:0]        tap_idx,
  output logic [BAND_W+TAP_W-1:0] coeff_addr,
  output logic                    acc_clear,
  output logic                    acc_last,
  output logic                    band_done,
  output logic [BAND_W-1:0]       band_done_idx,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    overrun
);

  localparam int DRAIN_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                               state_q, state_d;
  logic [BAND_W-1:0]                    band_q, band_d;
  logic [TAP_W-1:0]                     tap_q, tap_d;
  logic [DRAIN_W-1:0]                   drain_q, drain_d;
  logic                                 overrun_q, overrun_d;
  logic [MAC_LATENCY-1:0]               last_dly_q, last_dly_d;
  logic [MAC_LATENCY-1:0][BAND_W-1:0]   bidx_dly_q, bidx_dly_d;
  logic                                 tap_last_s;
  logic                                 band_last_s;

  // Stall gates the issue in the same cycle, so the strobe is decoded from the live input.
  assign clk_enable    = (state_q == S_RUN) && !stall;
  assign tap_last_s    = (tap_q == TAP_W'(TAPS - 1));
  assign band_last_s   = (band_q == BAND_W'(NUM_BANDS - 1));
  assign acc_clear     = clk_enable && (tap_q == {TAP_W{1'b0}});
  assign acc_last      = clk_enable && tap_last_s;
  assign band_idx      = band_q;
  assign tap_idx       = tap_q;
  assign coeff_addr    = {band_q, tap_q};
  assign sample_ready  = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = (state_q == S_DONE);
  assign overrun       = overrun_q;
  assign band_done     = last_dly_q[MAC_LATENCY-1];
  assign band_done_idx = bidx_dly_q[MAC_LATENCY-1];

  // Next-state, counter, overrun and completion-delay logic.
  always_comb begin
    state_d    = state_q;
    band_d     = band_q;
    tap_d      = tap_q;
    drain_d    = drain_q;
    last_dly_d = last_dly_q;
    bidx_dly_d = bidx_dly_q;
    case (state_q)
      S_IDLE: begin
        band_d  = {BAND_W{1'b0}};
        tap_d   = {TAP_W{1'b0}};
        drain_d = {DRAIN_W{1'b0}};
        if (sample_valid) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (clk_enable) begin
          tap_d = tap_q + TAP_W'(1);
          if (tap_last_s && band_last_s) begin
            band_d  = {BAND_W{1'b0}};
            state_d = S_DRAIN;
          end else if (tap_last_s) begin
            band_d = band_q + BAND_W'(1);
          end else begin
            band_d = band_q;
          end
        end else begin
          tap_d = tap_q;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_W'(MAC_LATENCY - 1)) begin
          drain_d = {DRAIN_W{1'b0}};
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A sample arriving while the frame is busy is dropped; a new one beats a clear.
    if (sample_valid && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    last_dly_d[0] = acc_last;
    bidx_dly_d[0] = band_q;
    for (int i = 1; i < MAC_LATENCY; i++) begin
      last_dly_d[i] = last_dly_q[i-1];
      bidx_dly_d[i] = bidx_dly_q[i-1];
    end
  end

  // State register; reset also empties the completion delay line so an aborted frame reports nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      band_q     <= {BAND_W{1'b0}};
      tap_q      <= {TAP_W{1'b0}};
      drain_q    <= {DRAIN_W{1'b0}};
      overrun_q  <= 1'b0;
      last_dly_q <= {MAC_LATENCY{1'b0}};
      bidx_dly_q <= {(MAC_LATENCY*BAND_W){1'b0}};
    end else begin
      state_q    <= state_d;
      band_q     <= band_d;
      tap_q      <= tap_d;
      drain_q    <= drain_d;
      overrun_q  <= overrun_d;
      last_dly_q <= last_dly_d;
      bidx_dly_q <= bidx_dly_d;
    end
  end

endmodule

// File: tb/tb_eq_mac_scheduler.sv
// Directed + randomized bench for eq_mac_scheduler, checked each cycle against
// a frame-level model (issue count, drain count, pending completion events).
module tb_eq_mac_scheduler;
  localparam int NB  = 8;
  localparam int TP  = 64;
  localparam int BW  = 3;
  localparam int TW  = 6;
  localparam int ML  = 2;
  localparam int TOT = NB * TP;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sample_valid = 1'b0;
  logic stall = 1'b0;
  logic overrun_clr = 1'b0;
  logic sample_ready, clk_enable, acc_clear, acc_last, band_done, frame_done, busy, overrun;
  logic [BW-1:0] band_idx, band_done_idx;
  logic [TW-1:0] tap_idx;
  logic [BW+TW-1:0] coeff_addr;

  always #5 clk = ~clk;

  eq_mac_scheduler #(.NUM_BANDS(NB), .TAPS(TP), .BAND_W(BW), .TAP_W(TW), .MAC_LATENCY(ML)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .stall(stall), .overrun_clr(overrun_clr), .clk_enable(clk_enable), .band_idx(band_idx),
    .tap_idx(tap_idx), .coeff_addr(coeff_addr), .acc_clear(acc_clear), .acc_last(acc_last),
    .band_done(band_done), .band_done_idx(band_done_idx), .frame_done(frame_done),
    .busy(busy), .overrun(overrun)
  );

  typedef struct {int due; int band;} bd_t;
  bd_t bd_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  bit  m_act = 1'b0;
  int  m_n = 0;
  int  m_post = 0;
  bit  m_ovr = 1'b0;
  int  stall_left = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_n = 0; m_post = 0; m_ovr = 1'b0;
    bd_q.delete();
  endtask

  task automatic check_outputs(input bit st);
    bit issuing, e_ce, e_bd, e_fd;
    int e_band, e_tap, e_bdi;
    issuing = m_act && (m_n < TOT);
    e_ce    = issuing && !st;
    e_band  = issuing ? m_n / TP : 0;
    e_tap   = issuing ? m_n % TP : 0;
    e_fd    = m_act && (m_n == TOT) && (m_post == ML + 1);
    e_bd    = (bd_q.size() > 0) && (bd_q[0].due == cyc);
    e_bdi   = e_bd ? bd_q[0].band : 0;
    chk("sample_ready", sample_ready, !m_act);
    chk("busy", busy, m_act);
    chk("clk_enable", clk_enable, e_ce);
    chk("band_idx", band_idx, e_band);
    chk("tap_idx", tap_idx, e_tap);
    chk("coeff_addr", coeff_addr, e_band * TP + e_tap);
    chk("acc_clear", acc_clear, e_ce && (e_tap == 0));
    chk("acc_last", acc_last, e_ce && (e_tap == TP - 1));
    chk("frame_done", frame_done, e_fd);
    chk("band_done", band_done, e_bd);
    if (e_bd) chk("band_done_idx", band_done_idx, e_bdi);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic model_update(input bit sv, input bit st, input bit clr);
    bit was_busy;
    was_busy = m_act;
    if ((bd_q.size() > 0) && (bd_q[0].due == cyc)) void'(bd_q.pop_front());
    if (!m_act) begin
      if (sv) begin m_act = 1'b1; m_n = 0; m_post = 0; end
    end else if (m_n < TOT) begin
      if (!st) begin
        if (m_n % TP == TP - 1) bd_q.push_back('{due: cyc + ML, band: m_n / TP});
        m_n++;
        if (m_n == TOT) m_post = 1;
      end
    end else if (m_post == ML + 1) begin
      m_act = 1'b0;
    end else begin
      m_post++;
    end
    m_ovr = (sv && was_busy) ? 1'b1 : (clr ? 1'b0 : m_ovr);
    cyc++;
  endtask

  task automatic tick(input bit sv, input bit st, input bit clr);
    @(negedge clk);
    sample_valid = sv; stall = st; overrun_clr = clr;
    #1;
    check_outputs(st);
    model_update(sv, st, clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; sample_valid = 1'b0; stall = 1'b0; overrun_clr = 1'b0;
    #1;
    model_reset();
    check_outputs(1'b0);
    model_update(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check_outputs(1'b0);
    model_update(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs(1'b0);
    model_update(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs(1'b0);
    do_reset();

    // Plain frame, no stall.
    repeat (7) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    repeat (520) tick(1'b0, 1'b0, 1'b0);

    // Three-cycle stall at band 2 tap 10.
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 525; i++) begin
      if (m_act && (m_n == 2 * TP + 10) && (stall_left == 0) && (i < 200)) stall_left = 3;
      tick(1'b0, stall_left > 0, 1'b0);
      if (stall_left > 0) stall_left--;
    end

    // Overrun set during RUN, clear racing a new sample, then a lone clear.
    tick(1'b1, 1'b0, 1'b0);
    repeat (189) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    repeat (99) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    repeat (99) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    repeat (130) tick(1'b0, 1'b0, 1'b0);

    // Randomized sample/stall/clear traffic.
    for (int i = 0; i < 1800; i++) begin
      tick($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 2);
    end
    repeat (600) tick(1'b0, 1'b0, 1'b0);

    // Reset mid-frame, then a fresh frame from band 0 tap 0.
    tick(1'b1, 1'b0, 1'b0);
    repeat (150) tick(1'b0, 1'b0, 1'b0);
    do_reset();
    repeat (5) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    repeat (520) tick(1'b0, 1'b0, 1'b0);

    // sample_valid held high: back-to-back frames.
    repeat (1100) tick(1'b1, 1'b0, 1'b0);
    repeat (520) tick(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
